dec2x4_scan_ctrl: RTL and testbench

Scan controller that sits directly upstream of the Dec2x4 2-to-4 decoder (active-high enable) and drives its `E` and `A[1:0]` inputs. It steps a 2-bit digit index through the active digits of a multiplexed 4-digit display. Each digit slot starts with a blanking interval (E low, anti-ghosting) followed by a dwell interval (E high). It pulses `frame_done` once per complete scan. Outputs connect straight to Dec2x4 `.E`/`.A`.

---
 rtl/dec2x4_scan_ctrl.sv | 98 +++++++++
 tb/tb_dec2x4_scan_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dec2x4_scan_ctrl.sv
// Digit scan controller feeding a Dec2x4 decoder: steps A through the active
// digits. Each slot is BLANK cycles with E low, then DWELL cycles with E driven.
module dec2x4_scan_ctrl #(
    parameter int DWELL = 8,
    parameter int BLANK = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [1:0] num_digits,
    input  logic [3:0] blank_mask,
    output logic       E,
    output logic [1:0] A,
    output logic       frame_done
);

    localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);

    typedef enum logic [1:0] {IDLE, BLNK, DRV} state_t;

    // With no blanking interval every slot begins directly in DRV.
    localparam state_t SLOT_START = (BLANK == 0) ? DRV : BLNK;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [1:0]    a_nx;
    logic          e_nx, fd_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            E          <= 1'b0;
            A          <= 2'b00;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            E          <= e_nx;
            A          <= a_nx;
            frame_done <= fd_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        a_nx     = A;
        fd_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (run) begin
                    state_nx = SLOT_START;
                    cnt_nx   = '0;
                    a_nx     = 2'b00;
                end
            end
            BLNK: begin
                if (cnt == BLANK_LAST) begin
                    state_nx = DRV;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DRV: begin
                if (cnt == DWELL_LAST) begin
                    state_nx = SLOT_START;
                    cnt_nx   = '0;
                    // >= also catches num_digits shrunk below the current digit
                    if (A >= num_digits) begin
                        a_nx  = 2'b00;
                        fd_nx = ~frame_done;
                    end else begin
                        a_nx = A + 2'd1;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (state != IDLE && !run) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            a_nx     = 2'b00;
            fd_nx    = 1'b0;
        end

        // E tracks the mask bit of the digit being selected on this same edge.
        e_nx = (state_nx == DRV) && !blank_mask[a_nx];
    end

endmodule

// File: tb/tb_dec2x4_scan_ctrl.sv
// Scoreboard bench for dec2x4_scan_ctrl: a slot-position model predicts each
// cycle's outputs into a queue and the negedge monitor drains it.
module tb_dec2x4_scan_ctrl;

    localparam int DWELL = 8;
    localparam int BLANK = 2;
    localparam int SLOT  = BLANK + DWELL;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic [1:0] num_digits;
    logic [3:0] blank_mask;
    logic       E;
    logic [1:0] A;
    logic       frame_done;

    typedef struct packed {
        logic       e;
        logic [1:0] a;
        logic       fd;
    } exp_t;

    exp_t q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // Model: whether scanning, current digit, position within the slot.
    bit m_act;
    int m_d;
    int m_p;
    bit m_fd;

    dec2x4_scan_ctrl #(.DWELL(DWELL), .BLANK(BLANK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .num_digits (num_digits),
        .blank_mask (blank_mask),
        .E          (E),
        .A          (A),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic exp_t model_out();
        exp_t x;
        x.e  = m_act && (m_p >= BLANK) && !blank_mask[m_d];
        x.a  = 2'(m_d);
        x.fd = m_fd;
        return x;
    endfunction

    task automatic model_reset();
        m_act = 0; m_d = 0; m_p = 0; m_fd = 0;
    endtask

    // One clock: model advances with the inputs present at the edge, then
    // the caller may change inputs 1 time unit later.
    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (!run) begin
                model_reset();
            end else if (!m_act) begin
                m_act = 1; m_d = 0; m_p = 0; m_fd = 0;
            end else begin
                m_p++;
                m_fd = 0;
                if (m_p == SLOT) begin
                    m_p = 0;
                    if (m_d >= int'(num_digits)) begin
                        m_d = 0;
                        m_fd = 1;
                    end else begin
                        m_d++;
                    end
                end
            end
            q.push_back(model_out());
        end
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_pos(input int d, input int p, input string tag);
        int n = 0;
        while (!(m_act && m_d == d && m_p == p) && n < 400) begin
            step();
            n++;
        end
        if (n >= 400) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: timed out waiting for digit %0d pos %0d", tag, d, p);
        end
    endtask

    task automatic check_zero(input string tag);
        vectors++;
        if (E !== 1'b0 || A !== 2'b00 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: got E=%b A=%b fd=%b, want E=0 A=00 fd=0",
                     tag, E, A, frame_done);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            vectors++;
            if ({E, A, frame_done} !== x) begin
                miscompares++;
                $display("FAIL scan t=%0t: got E=%b A=%b fd=%b, want E=%b A=%b fd=%b",
                         $time, E, A, frame_done, x.e, x.a, x.fd);
            end
        end
    end

    initial begin
        model_reset();
        rst_n      = 1'b0;
        run        = 1'b1;
        num_digits = 2'd3;
        blank_mask = 4'b0000;

        // Reset held with run high: outputs stay zero.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_zero("reset_hold");
        end
        rst_n = 1'b1;

        // Full 4-digit scan.
        steps(90);

        // Partial scan, 2 digits.
        num_digits = 2'd1;
        steps(60);

        // Shrink num_digits while on digit 2: wrap at end of that slot.
        num_digits = 2'd3;
        wait_pos(2, BLANK + 1, "shrink_wait");
        num_digits = 2'd0;
        steps(30);

        // Mask digit 2, then set mask bit 0 mid-dwell of digit 0.
        num_digits = 2'd3;
        blank_mask = 4'b0100;
        steps(50);
        wait_pos(0, BLANK + 3, "mask_wait");
        blank_mask = 4'b0101;
        steps(15);
        blank_mask = 4'b0000;

        // Stop in the 4th DRV cycle of digit 2, then restart.
        wait_pos(2, BLANK + 3, "stop_wait");
        run = 1'b0;
        steps(5);
        run = 1'b1;
        steps(45);

        // Randomized run/num_digits/mask traffic.
        for (int i = 0; i < 2000; i++) begin
            run = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 19) == 0) num_digits = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0)  blank_mask = 4'($urandom_range(0, 15));
            step();
        end

        // Async reset between edges during DRV of digit 3.
        run        = 1'b1;
        num_digits = 2'd3;
        blank_mask = 4'b0000;
        wait_pos(3, BLANK + 2, "areset_wait");
        #6;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        steps(2);
        rst_n = 1'b1;
        steps(30);

        @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expected outputs never checked", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
